// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit/receive blocks.
//   uart_state_e     frame sequencer states
//   MIN_DIV_DEFAULT  default lower clamp for the baud divisor (clocks per bit)
//   uart_div_eff()   clamps a requested divisor to the minimum
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned MIN_DIV_DEFAULT = 2;

    function automatic logic [31:0] uart_div_eff(input logic [31:0] div,
                                                 input logic [31:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset
//   i_div      clocks per bit (caller guarantees >= 2)
//   i_run      count while high; low holds the counter at zero
//   o_bit_end  high in the last clock of each bit period (count == i_div-1)
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_run,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == (i_div - DIV_W'(1)));
    assign o_bit_end = i_run && w_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input and
// gapless back-to-back frames. Frame = start, DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits. Divisor and config sampled at accept.
// Optional feature macro: UART_TX_PARITY_EN (adds cfg_par_odd and the parity bit).
// Ports:
//   sys_clk      clock
//   rst          asynchronous active-high reset
//   cfg_div      clocks per bit, clamped to MIN_DIV
//   cfg_stop2    0: one stop bit, 1: two stop bits
//   cfg_par_odd  1: odd parity, 0: even (UART_TX_PARITY_EN only)
//   tx_data      payload
//   tx_valid     payload valid
//   tx_ready     transfer happens when tx_valid && tx_ready
//   uart_tx      serial line, idle high, registered
//   tx_busy      high while a frame is on the line
//   tx_done      pulse in the last clock of the final stop bit
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned MIN_DIV = MIN_DIV_DEFAULT
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_stop2,
`ifdef UART_TX_PARITY_EN
    input  logic              cfg_par_odd,
`endif
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned IDX_W = 4;

    uart_state_e       r_state;
    uart_state_e       w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [DIV_W-1:0]  r_div;
    logic              r_stop2;
    logic              r_stop_cnt;
    logic              r_tx;
`ifdef UART_TX_PARITY_EN
    logic              r_par;
`endif
    logic              w_tx_next;
    logic              w_bit_end;
    logic              w_frame_end;
    logic              w_accept;
    logic              w_last_data;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .i_clk    (sys_clk),
        .i_rst    (rst),
        .i_div    (r_div),
        .i_run    (r_state != IDLE),
        .o_bit_end(w_bit_end)
    );

    assign w_last_data = (r_bit_idx == IDX_W'(DATA_W - 1));
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_stop_cnt == r_stop2);
    // Held low during reset even though the state register already reads IDLE.
    assign tx_ready    = !rst && ((r_state == IDLE) || w_frame_end);
    assign w_accept    = tx_valid && tx_ready;
    assign tx_done     = w_frame_end;
    assign tx_busy     = (r_state != IDLE);
    assign uart_tx     = r_tx;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_tx_next is the line level for the state being entered, so the
    // registered output changes in the same clock as the state.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_end) begin
                    if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_tx_next    = r_par;
`else
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next = r_par;
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                w_tx_next = 1'b1;
                if (w_frame_end) begin
                    if (w_accept) begin
                        w_state_next = START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_div      <= DIV_W'(MIN_DIV);
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_next;
            if (w_accept) begin
                r_shift    <= tx_data;
                r_bit_idx  <= '0;
                r_div      <= DIV_W'(uart_div_eff(32'(cfg_div), 32'(MIN_DIV)));
                r_stop2    <= cfg_stop2;
                r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_par      <= (^tx_data) ^ cfg_par_odd;
`endif
            end else if (w_bit_end) begin
                case (r_state)
                    DATA: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                    STOP: begin
                        r_stop_cnt <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic [DIV_W-1:0]  cfg_div = 16'd4;
    logic              cfg_stop2 = 1'b0;
    logic              cfg_par_odd = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              uart_tx;
    logic              tx_busy;
    logic              tx_done;

    uart_tx_frame #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .MIN_DIV(2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_PARITY_EN
        .cfg_par_odd(cfg_par_odd),
`endif
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic line;
        logic done;
        logic ready;
        logic busy;
    } obs_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       div;
        bit                stop2;
        bit                par_odd;
        int                clks;
    } vec_t;

    obs_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Per-clock expectation for one frame, built from the serial-frame definition.
    task automatic push_frame(input logic [DATA_W-1:0] d, input int unsigned dv,
                              input bit s2, input bit po);
        int unsigned de;
        logic        bits[$];
        obs_t        e;
        de = (dv < 2) ? 2 : dv;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DATA_W); i++) bits.push_back(d[i]);
        if (PAR == 1) bits.push_back((^d) ^ po);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int unsigned c = 0; c < de; c++) begin
                e.line  = bits[b];
                e.done  = (b == bits.size() - 1) && (c == de - 1);
                e.ready = e.done;
                e.busy  = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard consumer: one expectation per clock, idle line when empty.
    always @(negedge sys_clk) begin
        obs_t e;
        obs_t act;
        cyc++;
        if (mon_en && !rst) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{line: 1'b1, done: 1'b0, ready: 1'b1, busy: 1'b0};
            act = {uart_tx, tx_done, tx_ready, tx_busy};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL line_cyc%0d tx/done/ready/busy got=%b exp=%b", cyc, act, e);
            end
            if (tx_done) done_q.push_back(cyc);
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input int unsigned dv, input bit s2,
                        input bit po, input bit hold, output int acc);
        bit rdy;
        int n;
        n        = 0;
        acc      = -1;
        tx_data  = d;
        cfg_div  = DIV_W'(dv);
        cfg_stop2 = s2;
        cfg_par_odd = po;
        tx_valid = 1'b1;
        while (acc < 0 && n < 500) begin
            rdy = tx_ready;
            @(posedge sys_clk);
            #1;
            n++;
            if (rdy) begin
                push_frame(d, dv, s2, po);
                acc = cyc;
            end
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=none exp=accept");
        end
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_len(input string name, input int acc, input int clks);
        int d;
        if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=no_done exp=%0d", name, clks);
        end else begin
            d = done_q.pop_front();
            check(name, d - acc, clks);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   a, a2, d1, d2;

        vecs[0] = '{8'hA5, 4, 1'b0, 1'b0, 4 * (10 + PAR)};
        vecs[1] = '{8'hA5, 4, 1'b0, 1'b1, 4 * (10 + PAR)};
        vecs[2] = '{8'h00, 4, 1'b1, 1'b0, 4 * (11 + PAR)};
        vecs[3] = '{8'hFF, 3, 1'b0, 1'b1, 3 * (10 + PAR)};
        vecs[4] = '{8'h5A, 0, 1'b0, 1'b0, 2 * (10 + PAR)};
        vecs[5] = '{8'h3C, 1, 1'b0, 1'b1, 2 * (10 + PAR)};
        vecs[6] = '{8'h01, 2, 1'b1, 1'b0, 2 * (11 + PAR)};
        vecs[7] = '{8'h80, 5, 1'b1, 1'b1, 5 * (11 + PAR)};

        // Reset state, then release.
        #12;
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_ready", int'(tx_ready), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        @(posedge sys_clk);
        #3 rst = 1'b0;
        #1 check("post_rst_ready", int'(tx_ready), 1);
        mon_en = 1'b1;
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].div, vecs[i].stop2, vecs[i].par_odd, 1'b0, a);
            wait_drain();
            check_len($sformatf("vec%0d_len", i), a, vecs[i].clks);
            repeat (3) @(posedge sys_clk);
            #1;
        end

        // Back-to-back with tx_valid held: no idle gap between frames.
        send(8'h00, 4, 1'b0, 1'b0, 1'b1, a);
        send(8'hFF, 4, 1'b0, 1'b0, 1'b0, a2);
        wait_drain();
        if (done_q.size() < 2) begin
            checks++;
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=2", done_q.size());
            done_q.delete();
        end else begin
            d1 = done_q.pop_front();
            d2 = done_q.pop_front();
            check("b2b_len1", d1 - a, 4 * (10 + PAR));
            check("b2b_gap", a2 - d1, 0);
            check("b2b_spacing", d2 - d1, 4 * (10 + PAR));
        end
        repeat (2) @(posedge sys_clk);
        #1;

        // Config changed mid-frame must not affect the frame in flight.
        send(8'hC3, 0, 1'b0, 1'b0, 1'b0, a);
        repeat (5) @(posedge sys_clk);
        #1;
        cfg_div   = 16'd9;
        cfg_stop2 = 1'b1;
        wait_drain();
        check_len("midcfg_len", a, 2 * (10 + PAR));
        repeat (2) @(posedge sys_clk);
        #1;

        // Asynchronous reset in clock 15 of a frame (a data bit of 0x00 is low).
        send(8'h00, 4, 1'b0, 1'b0, 1'b0, a);
        repeat (14) @(posedge sys_clk);
        #3;
        check("pre_rst_line", int'(uart_tx), 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_line", int'(uart_tx), 1);
        check("async_rst_busy", int'(tx_busy), 0);
        check("async_rst_ready", int'(tx_ready), 0);
        repeat (2) @(posedge sys_clk);
        #3 rst = 1'b0;
        done_q.delete();
        #1;
        check("rel_ready", int'(tx_ready), 1);
        check("rel_busy", int'(tx_busy), 0);
        @(posedge sys_clk);
        #1;
        send(8'h3C, 3, 1'b1, 1'b1, 1'b0, a);
        wait_drain();
        check_len("post_rst_len", a, 3 * (11 + PAR));
        repeat (3) @(posedge sys_clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
